// File: rtl/conv_psum_accum_pkg.sv
// Shared constants and state encoding for the partial-sum accumulator.
// Latency: n/a (package only).
// Backpressure: n/a.
package conv_psum_accum_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int PSUM_WIDTH = 24;
    localparam int FRAC_BITS  = 9;
    localparam int CNT_WIDTH  = 10;

    // Clamp limits for a signed DATA_WIDTH result.
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // 3.0 in Q.FRAC_BITS (1536), also used by the hard-swish stage.
    localparam logic signed [DATA_WIDTH-1:0] Q9_THREE = DATA_WIDTH'(3 << FRAC_BITS);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/conv_psum_accum_if.sv
// Control/data bundle between the MAC array side and the accumulator.
// Latency: n/a (signal bundle only).
// Backpressure: none; the consumer of acc_out always accepts.
interface conv_psum_accum_if;
    import conv_psum_accum_pkg::*;

    logic                         start;
    logic [CNT_WIDTH-1:0]         cfg_terms;
    logic [CNT_WIDTH-1:0]         cfg_pixels;
    logic signed [DATA_WIDTH-1:0] bias;
    logic signed [PSUM_WIDTH-1:0] psum;
    logic                         psum_valid;
    logic                         ready;
    logic signed [DATA_WIDTH-1:0] acc_out;
    logic                         acc_valid;
    logic                         done;
    logic                         sat_flag;

    modport master (
        output start, cfg_terms, cfg_pixels, bias, psum, psum_valid,
        input  ready, acc_out, acc_valid, done, sat_flag
    );

    modport slave (
        input  start, cfg_terms, cfg_pixels, bias, psum, psum_valid,
        output ready, acc_out, acc_valid, done, sat_flag
    );

endinterface

// File: rtl/conv_psum_accum_sat_add.sv
// Signed add one bit wider than the operands, then clamp back to DATA_WIDTH.
// Latency: combinational.
// Backpressure: none.
module sat_add
    import conv_psum_accum_pkg::*;
(
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] sum_o,
    output logic                         ovf_o
);

    logic signed [DATA_WIDTH:0] wide;

    assign wide  = {a_i[DATA_WIDTH-1], a_i} + {b_i[DATA_WIDTH-1], b_i};
    // The top two bits disagree exactly when the true sum leaves the DATA_WIDTH range.
    assign ovf_o = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];

    // Clamp toward the sign of the wide result.
    always_comb begin
        sum_o = wide[DATA_WIDTH-1:0];
        if (ovf_o) begin
            sum_o = wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/conv_psum_accum.sv
// Accumulates cfg_terms psums plus bias per pixel, saturates, strobes one result per pixel.
// Latency: acc_valid one cycle after the edge accepting a pixel's last psum.
// Backpressure: none; psum_valid-gapped input just holds state, output is never stalled.
module conv_psum_accum
    import conv_psum_accum_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    conv_psum_accum_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                       state_q, state_d;
    logic [CNT_WIDTH-1:0]         terms_q, terms_d;
    logic [CNT_WIDTH-1:0]         pixels_q, pixels_d;
    logic [CNT_WIDTH-1:0]         term_cnt_q, term_cnt_d;
    logic [CNT_WIDTH-1:0]         pix_cnt_q, pix_cnt_d;
    logic signed [DATA_WIDTH-1:0] bias_q, bias_d;
    logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] acc_out_q, acc_out_d;
    logic                         acc_valid_q, acc_valid_d;
    logic                         done_q, done_d;
    logic                         sat_flag_q, sat_flag_d;

    logic signed [DATA_WIDTH-1:0] psum_ext;
    logic signed [DATA_WIDTH-1:0] sum_sat;
    logic                         sum_ovf;

    assign psum_ext = {{(DATA_WIDTH-PSUM_WIDTH){bus.psum[PSUM_WIDTH-1]}}, bus.psum};

    sat_add u_sat_add (
        .a_i   (acc_q),
        .b_i   (psum_ext),
        .sum_o (sum_sat),
        .ovf_o (sum_ovf)
    );

    // Next-state: run setup on start in IDLE, term/pixel stepping on each valid psum in ACCUM.
    always_comb begin
        state_d     = state_q;
        terms_d     = terms_q;
        pixels_d    = pixels_q;
        term_cnt_d  = term_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        bias_d      = bias_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = 1'b0;
        done_d      = 1'b0;
        sat_flag_d  = sat_flag_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    terms_d    = (bus.cfg_terms  == '0) ? CNT_ONE : bus.cfg_terms;
                    pixels_d   = (bus.cfg_pixels == '0) ? CNT_ONE : bus.cfg_pixels;
                    bias_d     = bus.bias;
                    acc_d      = bus.bias;
                    term_cnt_d = '0;
                    pix_cnt_d  = '0;
                    sat_flag_d = 1'b0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.psum_valid) begin
                    sat_flag_d = sat_flag_q | sum_ovf;
                    if (term_cnt_q == terms_q - CNT_ONE) begin
                        acc_out_d   = sum_sat;
                        acc_valid_d = 1'b1;
                        acc_d       = bias_q;
                        term_cnt_d  = '0;
                        if (pix_cnt_q == pixels_q - CNT_ONE) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            pix_cnt_d = pix_cnt_q + CNT_ONE;
                        end
                    end else begin
                        acc_d      = sum_sat;
                        term_cnt_d = term_cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Latched run configuration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            terms_q  <= '0;
            pixels_q <= '0;
            bias_q   <= '0;
        end else begin
            terms_q  <= terms_d;
            pixels_q <= pixels_d;
            bias_q   <= bias_d;
        end
    end

    // Running sum and term/pixel counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            term_cnt_q <= '0;
            pix_cnt_q  <= '0;
        end else begin
            acc_q      <= acc_d;
            term_cnt_q <= term_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
        end
    end

    // Output result, strobes and sticky saturation flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            done_q      <= 1'b0;
            sat_flag_q  <= 1'b0;
        end else begin
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            done_q      <= done_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.acc_out   = acc_out_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.done      = done_q;
    assign bus.sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_conv_psum_accum.sv
// Bench for conv_psum_accum: directed table, corner sequences and random runs vs a reference model.
// Latency: results expected on the cycle after each pixel's last accepted psum.
// Backpressure: none exercised; psum_valid gaps are.
module tb_conv_psum_accum;
    import conv_psum_accum_pkg::*;

    logic clk;
    logic rst_n;

    conv_psum_accum_if bus ();

    conv_psum_accum dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint out;
        bit     sat;
        bit     last;
    } exp_t;

    typedef struct {
        int     terms;
        longint bias;
        longint p0, p1, p2, p3;
        int     gap;
        longint exp_out;
        bit     exp_sat;
    } vec_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    exp_t   exp_q[$];
    longint stim_q[$];
    longint last_out;
    bit     last_sat;
    longint MAXV;
    longint MINV;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: per pixel start from bias, add each term with clamping; flag is sticky over the run.
    task automatic model_push(input int terms, input int pixels, input longint bias);
        int     t;
        int     p;
        int     idx;
        longint acc;
        bit     sat;
        exp_t   e;
        t   = (terms == 0) ? 1 : terms;
        p   = (pixels == 0) ? 1 : pixels;
        idx = 0;
        sat = 1'b0;
        for (int i = 0; i < p; i++) begin
            acc = bias;
            for (int j = 0; j < t; j++) begin
                acc = acc + stim_q[idx];
                idx++;
                if (acc > MAXV) begin acc = MAXV; sat = 1'b1; end
                else if (acc < MINV) begin acc = MINV; sat = 1'b1; end
            end
            e.out  = acc;
            e.sat  = sat;
            e.last = (i == p - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.acc_valid) begin
            check("valid_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("acc_out", longint'(bus.acc_out), e.out);
                check("sat_flag", longint'(bus.sat_flag), longint'(e.sat));
                check("done", longint'(bus.done), longint'(e.last));
                if (e.last) check("ready_at_done", longint'(bus.ready), 1);
                last_out = longint'(bus.acc_out);
                last_sat = bus.sat_flag;
            end
        end else begin
            check("done_without_valid", longint'(bus.done), 0);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 20) begin
            tick();
            k++;
        end
        check("pending_results", longint'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    // Full run: start (optionally with a psum that must be dropped), feed stim_q with gaps.
    task automatic run(input int terms, input int pixels, input longint bias,
                       input int gap, input bit junk);
        model_push(terms, pixels, bias);
        bus.start      = 1'b1;
        bus.cfg_terms  = CNT_WIDTH'(terms);
        bus.cfg_pixels = CNT_WIDTH'(pixels);
        bus.bias       = DATA_WIDTH'(bias);
        bus.psum_valid = junk;
        bus.psum       = 24'h3fffff;
        tick();
        bus.start      = 1'b0;
        bus.psum_valid = 1'b0;
        check("ready_drop", longint'(bus.ready), 0);
        check("sat_clear", longint'(bus.sat_flag), 0);
        foreach (stim_q[i]) begin
            bus.psum       = PSUM_WIDTH'(stim_q[i]);
            bus.psum_valid = 1'b1;
            tick();
            bus.psum_valid = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
        drain();
        stim_q.delete();
    endtask

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        MAXV = 2147483647;
        MINV = -longint'(2147483647) - 1;

        tbl[0] = '{3, 1536, 512, -256, 1024, 0, 0, 2816, 1'b0};
        tbl[1] = '{3, 1536, 512, -256, 1024, 0, 2, 2816, 1'b0};
        tbl[2] = '{2, 2147483547, 200, 0, 0, 0, 0, 2147483647, 1'b1};
        tbl[3] = '{1, -5, -10, 0, 0, 0, 0, -15, 1'b0};
        tbl[4] = '{0, 7, 3, 0, 0, 0, 0, 10, 1'b0};
        tbl[5] = '{4, -2147483638, -100, 50, 0, 0, 0, -2147483598, 1'b1};
        tbl[6] = '{2, 0, -8388608, -8388608, 0, 0, 0, -16777216, 1'b0};
        tbl[7] = '{1, 2147483647, 1, 0, 0, 0, 0, 2147483647, 1'b1};

        bus.start      = 1'b0;
        bus.cfg_terms  = '0;
        bus.cfg_pixels = '0;
        bus.bias       = '0;
        bus.psum       = '0;
        bus.psum_valid = 1'b0;
        last_out       = 0;
        last_sat       = 1'b0;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", longint'(bus.ready), 1);
        check("rst_acc_out", longint'(bus.acc_out), 0);
        check("rst_acc_valid", longint'(bus.acc_valid), 0);
        check("rst_done", longint'(bus.done), 0);
        check("rst_sat_flag", longint'(bus.sat_flag), 0);

        // Directed single-pixel table.
        for (int v = 0; v < 8; v++) begin
            int nt;
            nt = (tbl[v].terms == 0) ? 1 : tbl[v].terms;
            stim_q.push_back(tbl[v].p0);
            if (nt > 1) stim_q.push_back(tbl[v].p1);
            if (nt > 2) stim_q.push_back(tbl[v].p2);
            if (nt > 3) stim_q.push_back(tbl[v].p3);
            run(tbl[v].terms, 1, tbl[v].bias, tbl[v].gap, 1'b0);
            check("tbl_out", last_out, tbl[v].exp_out);
            check("tbl_sat", longint'(last_sat), longint'(tbl[v].exp_sat));
        end

        // Streaming: one term per pixel, no bubbles.
        stim_q = '{10, 20, 30, 40};
        run(1, 4, 0, 0, 1'b1);
        check("stream_last", last_out, 40);

        // Abort mid-pixel with reset.
        bus.start      = 1'b1;
        bus.cfg_terms  = 10'd3;
        bus.cfg_pixels = 10'd1;
        bus.bias       = 32'sd1536;
        tick();
        bus.start = 1'b0;
        bus.psum  = 24'sd512;  bus.psum_valid = 1'b1; tick();
        bus.psum  = -24'sd256; tick();
        bus.psum_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #2;
        check("abort_ready_in_rst", longint'(bus.ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.psum = 24'sd1024; bus.psum_valid = 1'b1;
        tick();
        bus.psum_valid = 1'b0;
        check("abort_ready", longint'(bus.ready), 1);
        check("abort_acc_out", longint'(bus.acc_out), 0);
        repeat (3) tick();
        check("abort_no_valid", longint'(bus.acc_valid), 0);

        // Start pulsed during ACCUM must not disturb the run.
        stim_q = '{512, -256, 1024};
        model_push(3, 1, 1536);
        bus.start      = 1'b1;
        bus.cfg_terms  = 10'd3;
        bus.cfg_pixels = 10'd1;
        bus.bias       = 32'sd1536;
        tick();
        bus.start = 1'b0;
        bus.psum  = 24'sd512; bus.psum_valid = 1'b1; tick();
        bus.psum_valid = 1'b0;
        bus.start      = 1'b1;
        bus.cfg_terms  = 10'd1;
        bus.bias       = 32'sd0;
        tick();
        bus.start = 1'b0;
        bus.psum  = -24'sd256; bus.psum_valid = 1'b1; tick();
        bus.psum  = 24'sd1024; tick();
        bus.psum_valid = 1'b0;
        drain();
        stim_q.delete();
        check("start_ignored_out", last_out, 2816);

        // Random runs.
        for (int r = 0; r < 40; r++) begin
            int     t;
            int     p;
            int     tt;
            int     pp;
            longint b;
            t  = int'($urandom_range(0, 5));
            p  = int'($urandom_range(0, 4));
            tt = (t == 0) ? 1 : t;
            pp = (p == 0) ? 1 : p;
            case ($urandom_range(0, 2))
                0: b = MAXV - longint'($urandom_range(0, 20000000));
                1: b = MINV + longint'($urandom_range(0, 20000000));
                default: b = longint'($signed($urandom()));
            endcase
            for (int k = 0; k < tt * pp; k++) begin
                stim_q.push_back(longint'($urandom_range(0, 16777215)) - 8388608);
            end
            run(t, p, b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
